// File: rtl/nn_pkg.sv
// nn_pkg: shared loader state encoding and one-hot neuron select helper
package nn_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} loader_state_t;
  localparam int MAX_NEURON = 64;
  function automatic logic [MAX_NEURON-1:0] onehot(input int unsigned idx);
    return MAX_NEURON'(1) << idx;
  endfunction
endpackage

// File: rtl/weight_loader.sv
// weight_loader: streams numWeight words into the selected neuron's weight memory
module weight_loader
  import nn_pkg::*;
#(
  parameter int numWeight     = 3,
  parameter int addressWidth  = 10,
  parameter int dataWidth     = 16,
  parameter int numNeuron     = 4,
  parameter int neuronIdWidth = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [neuronIdWidth-1:0] neuron_sel,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [dataWidth-1:0]     s_data,
  input  logic                     s_last,
  output logic                     wr_en,
  output logic [addressWidth-1:0]  wr_addr,
  output logic [dataWidth-1:0]     wr_data,
  output logic [numNeuron-1:0]     wr_sel,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);
  if (numWeight < 1 || numWeight > 2**addressWidth || numNeuron < 1 ||
      numNeuron > MAX_NEURON || 2**neuronIdWidth < numNeuron) begin : g_param_check
    $error("weight_loader: illegal parameter combination");
  end
  localparam logic [addressWidth-1:0] LAST = addressWidth'(numWeight - 1);
  loader_state_t state_q, state_n;
  logic [addressWidth-1:0]  count_q;
  logic [neuronIdWidth-1:0] sel_q;
  logic sel_ok, start_ok, accept, final_beat;
  assign sel_ok     = 32'(neuron_sel) < numNeuron;
  assign start_ok   = state_q == IDLE && start && sel_ok;
  assign accept     = s_ready && s_valid;
  assign final_beat = accept && (count_q == LAST || s_last);
  assign s_ready    = state_q == LOAD;
  assign busy       = state_q == LOAD || state_q == FLUSH;
  assign done       = state_q == DONE;
  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    state_n = start_ok ? LOAD : IDLE;
      LOAD:    state_n = final_beat ? FLUSH : LOAD;
      FLUSH:   state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else     state_q <= state_n;
  // A frame is malformed when s_last disagrees with the final-address position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      sel_q   <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_sel  <= '0;
      err     <= 1'b0;
    end else begin
      wr_en  <= accept;
      wr_sel <= accept ? numNeuron'(onehot(32'(sel_q))) : '0;
      if (accept) begin
        wr_addr <= count_q;
        wr_data <= s_data;
        count_q <= count_q + addressWidth'(1);
        if ((count_q == LAST) ^ s_last) err <= 1'b1;
      end
      if (start_ok) begin
        sel_q   <= neuron_sel;
        count_q <= '0;
        err     <= 1'b0;
      end else if (state_q == IDLE && start) err <= 1'b1;
    end
  end
endmodule
